// File: rtl/lr35902_ppu_pkg.sv
// lr35902_ppu_pkg: shared PPU types and constants for the object search and line buffer.
package lr35902_ppu_pkg;
    localparam int OAM_NUM_OBJ  = 40;
    localparam int OBJ_PER_LINE = 10;
    localparam int OBJ_Y_OFS    = 16;

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
        logic [7:0] x;
        logic [3:0] line;
    } obj_slot_t;

    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;
endpackage

// File: rtl/lr35902_obj_buffer.sv
// lr35902_obj_buffer: per-line object slots with an X-match priority lookup and consume-clear.
module lr35902_obj_buffer
    import lr35902_ppu_pkg::*;
#(
    parameter int MAX_LINE = OBJ_PER_LINE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       we,
    input  logic [3:0] wslot,
    input  obj_slot_t  wdata,
    input  logic [7:0] x_pos,
    input  logic       consume,
    output logic       hit,
    output logic [5:0] hit_idx,
    output logic [3:0] hit_line
);
    obj_slot_t  slots [MAX_LINE];
    logic [3:0] sel;

    // Scan from the top so the lowest slot (lowest OAM index) wins.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = MAX_LINE - 1; k >= 0; k--)
            if (slots[k].valid && slots[k].x == x_pos) begin
                hit = 1'b1;
                sel = 4'(k);
            end
    end

    assign hit_idx  = slots[sel].idx;
    assign hit_line = slots[sel].line;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            for (int k = 0; k < MAX_LINE; k++) slots[k] <= '0;
        else if (clear)
            for (int k = 0; k < MAX_LINE; k++) slots[k].valid <= 1'b0;
        else begin
            if (we) slots[wslot] <= wdata;
            if (consume) slots[sel].valid <= 1'b0;
        end
endmodule

// File: rtl/lr35902_oam_scan.sv
// lr35902_oam_scan: mode-2 OAM search; picks the first objects overlapping LY into a line buffer.
module lr35902_oam_scan
    import lr35902_ppu_pkg::*;
#(
    parameter int NUM_OBJ  = OAM_NUM_OBJ,
    parameter int MAX_LINE = OBJ_PER_LINE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ly,
    input  logic        obj_size,
    output logic [7:0]  oam_adr,
    output logic        oam_read,
    input  logic [15:0] oam_dout16,
    output logic        busy,
    output logic        done,
    output logic [3:0]  count,
    input  logic [7:0]  x_pos,
    output logic        hit,
    output logic [5:0]  hit_idx,
    output logic [3:0]  hit_line,
    input  logic        consume
);
    scan_state_t state;
    logic [5:0]  i;
    logic        phase;
    logic [8:0]  d;
    logic        match, store, buf_hit;

    // 9-bit math: a Y below the line wraps d past 255, so it never matches.
    assign d     = {1'b0, ly} + 9'(OBJ_Y_OFS) - {1'b0, oam_dout16[7:0]};
    assign match = d < (obj_size ? 9'd16 : 9'd8);
    assign store = state == S_SCAN && phase && match && count < 4'(MAX_LINE);
    assign hit   = buf_hit && !busy;

    lr35902_obj_buffer #(.MAX_LINE(MAX_LINE)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .we      (store),
        .wslot   (count),
        .wdata   ('{valid: 1'b1, idx: i, x: oam_dout16[15:8], line: d[3:0]}),
        .x_pos   (x_pos),
        .consume (consume && hit),
        .hit     (buf_hit),
        .hit_idx (hit_idx),
        .hit_line(hit_line)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            oam_read <= 1'b0;
            oam_adr  <= '0;
            count    <= '0;
            i        <= '0;
            phase    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state    <= S_SCAN;
                busy     <= 1'b1;
                count    <= '0;
                i        <= '0;
                phase    <= 1'b0;
                oam_read <= 1'b1;
                oam_adr  <= '0;
            end else if (state == S_SCAN) begin
                if (!phase) begin
                    phase    <= 1'b1;
                    oam_read <= 1'b0;
                end else begin
                    if (store) count <= count + 4'd1;
                    if (i == 6'(NUM_OBJ - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        i        <= i + 6'd1;
                        phase    <= 1'b0;
                        oam_read <= 1'b1;
                        oam_adr  <= {i + 6'd1, 2'b00};
                    end
                end
            end
        end
endmodule

// File: tb/tb_lr35902_oam_scan.sv
// tb_lr35902_oam_scan: scoreboard bench for the mode-2 object search and line buffer.
module tb_lr35902_oam_scan;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, obj_size = 1'b0, consume = 1'b0;
    logic [7:0]  ly = '0, x_pos = '0, oam_adr;
    logic        oam_read, busy, done, hit;
    logic [15:0] oam_dout16 = '0;
    logic [3:0]  count, hit_line;
    logic [5:0]  hit_idx;
    logic [7:0]  oam_y [40];
    logic [7:0]  oam_x [40];

    typedef struct {
        logic [5:0] idx;
        logic [7:0] x;
        logic [3:0] line;
    } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0, n_bad = 0;

    lr35902_oam_scan dut (
        .clk(clk), .reset(reset), .start(start), .ly(ly), .obj_size(obj_size),
        .oam_adr(oam_adr), .oam_read(oam_read), .oam_dout16(oam_dout16),
        .busy(busy), .done(done), .count(count), .x_pos(x_pos),
        .hit(hit), .hit_idx(hit_idx), .hit_line(hit_line), .consume(consume)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (oam_read) oam_dout16 <= {oam_x[oam_adr[7:2]], oam_y[oam_adr[7:2]]};

    task automatic set_oam(input logic [7:0] y, input logic [7:0] x_base);
        for (int k = 0; k < 40; k++) begin
            oam_y[k] = y;
            oam_x[k] = x_base + 8'(k);
        end
    endtask

    task automatic push_expected();
        int h = obj_size ? 16 : 8;
        int n = 0;
        for (int k = 0; k < 40; k++) begin
            int dd = int'(ly) + 16 - int'(oam_y[k]);
            if (dd >= 0 && dd < h && n < 10) begin
                exp_q.push_back('{idx: 6'(k), x: oam_x[k], line: 4'(dd)});
                n++;
            end
        end
    endtask

    task automatic do_scan(input int restart_at, input logic [7:0] ly2,
                           output int done_cyc, output int busy_cnt);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        done_cyc = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 300; c++) begin
            if (c == restart_at) begin
                start = 1'b1;
                ly = ly2;
                exp_q.delete();
                push_expected();
            end
            if (c == restart_at + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain_scoreboard(input string tag);
        exp_t e[$];
        while (exp_q.size() > 0) e.push_back(exp_q.pop_front());
        @(negedge clk);
        n_cmp++;
        if (count !== 4'(e.size())) begin
            n_bad++;
            $display("FAIL %s count: got %0d expected %0d", tag, count, e.size());
        end
        foreach (e[k]) begin
            int f = k;
            for (int j = 0; j < k; j++)
                if (e[j].x == e[k].x) begin
                    f = j;
                    break;
                end
            @(negedge clk);
            x_pos = e[k].x;
            #1;
            n_cmp++;
            if (hit !== 1'b1) begin
                n_bad++;
                $display("FAIL %s hit x=%0d: got %b expected 1", tag, e[k].x, hit);
            end
            n_cmp++;
            if (hit_idx !== e[f].idx) begin
                n_bad++;
                $display("FAIL %s hit_idx x=%0d: got %0d expected %0d", tag, e[k].x, hit_idx, e[f].idx);
            end
            n_cmp++;
            if (hit_line !== e[f].line) begin
                n_bad++;
                $display("FAIL %s hit_line x=%0d: got %0d expected %0d", tag, e[k].x, hit_line, e[f].line);
            end
        end
    endtask

    task automatic test_reset();
        int dones = 0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, oam_read, hit} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset flags: got %b expected 0000", {busy, done, oam_read, hit});
        end
        n_cmp++;
        if (oam_adr !== 8'd0 || count !== 4'd0) begin
            n_bad++;
            $display("FAIL reset adr/count: got %0d/%0d expected 0/0", oam_adr, count);
        end
        @(posedge clk); #1 reset = 1'b0;
        set_oam(8'd16, 8'd1);
        ly = 8'd0;
        obj_size = 1'b0;
        x_pos = 8'd1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c < 30; c++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (busy !== 1'b1 || count !== 4'd10) begin
            n_bad++;
            $display("FAIL midscan busy/count: got %b/%0d expected 1/10", busy, count);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, oam_read, hit} !== 3'b000 || count !== 4'd0) begin
            n_bad++;
            $display("FAIL async reset busy/read/hit/count: got %b/%0d expected 000/0", {busy, oam_read, hit}, count);
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dones !== 0 || hit !== 1'b0) begin
            n_bad++;
            $display("FAIL post-reset done pulses/hit: got %0d/%b expected 0/0", dones, hit);
        end
    endtask

    task automatic test_single();
        int dc, bc;
        set_oam(8'd0, 8'd0);
        for (int k = 0; k < 40; k++) oam_x[k] = 8'd0;
        oam_y[0] = 8'd16;
        oam_x[0] = 8'd8;
        ly = 8'd0;
        obj_size = 1'b0;
        push_expected();
        do_scan(0, 8'd0, dc, bc);
        n_cmp++;
        if (dc !== 81 || bc !== 80) begin
            n_bad++;
            $display("FAIL single done/busy cycles: got %0d/%0d expected 81/80", dc, bc);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL single done width: got %b expected 0", done);
        end
        drain_scoreboard("single");
        @(negedge clk) x_pos = 8'd0;
        #1;
        n_cmp++;
        if (hit !== 1'b0) begin
            n_bad++;
            $display("FAIL single unmatched x0: got %b expected 0", hit);
        end
    endtask

    task automatic test_boundaries();
        int dc, bc;
        for (int s = 0; s < 2; s++) begin
            set_oam(8'd0, 8'd100);
            obj_size = s[0];
            oam_y[0] = s ? 8'd21 : 8'd29;
            oam_x[0] = 8'd10;
            oam_y[1] = s ? 8'd20 : 8'd28;
            oam_x[1] = 8'd11;
            oam_y[2] = 8'd200;
            oam_x[2] = 8'd12;
            ly = 8'd20;
            push_expected();
            do_scan(0, 8'd20, dc, bc);
            n_cmp++;
            if (dc !== 81) begin
                n_bad++;
                $display("FAIL boundary size%0d done cycle: got %0d expected 81", s, dc);
            end
            drain_scoreboard(s ? "bound16" : "bound8");
            for (int a = 11; a <= 12; a++) begin
                @(negedge clk) x_pos = 8'(a);
                #1;
                n_cmp++;
                if (hit !== 1'b0) begin
                    n_bad++;
                    $display("FAIL boundary size%0d x=%0d stored: got %b expected 0", s, a, hit);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int dc, bc;
        ly = 8'd50;
        obj_size = 1'b0;
        for (int k = 0; k < 40; k++) begin
            oam_y[k] = 8'(66 - (k % 8));
            oam_x[k] = 8'(k + 1);
        end
        push_expected();
        do_scan(0, 8'd0, dc, bc);
        n_cmp++;
        if (dc !== 81 || bc !== 80) begin
            n_bad++;
            $display("FAIL overflow done/busy cycles: got %0d/%0d expected 81/80", dc, bc);
        end
        drain_scoreboard("overflow");
        @(negedge clk) x_pos = 8'd11;
        #1;
        n_cmp++;
        if (hit !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow entry10 present: got %b expected 0", hit);
        end
    endtask

    task automatic test_consume();
        int dc, bc;
        set_oam(8'd0, 8'd200);
        oam_y[3] = 8'd16; oam_x[3] = 8'd50;
        oam_y[7] = 8'd16; oam_x[7] = 8'd50;
        oam_y[9] = 8'd16; oam_x[9] = 8'd0;
        ly = 8'd0;
        obj_size = 1'b0;
        push_expected();
        do_scan(0, 8'd0, dc, bc);
        drain_scoreboard("consume");
        @(negedge clk) x_pos = 8'd50;
        #1;
        n_cmp++;
        if (hit !== 1'b1 || hit_idx !== 6'd3) begin
            n_bad++;
            $display("FAIL consume first: got hit=%b idx=%0d expected 1/3", hit, hit_idx);
        end
        @(posedge clk); #1 consume = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (hit !== 1'b1 || hit_idx !== 6'd7) begin
            n_bad++;
            $display("FAIL consume second: got hit=%b idx=%0d expected 1/7", hit, hit_idx);
        end
        @(posedge clk); #1 consume = 1'b0;
        n_cmp++;
        if (hit !== 1'b0 || count !== 4'd3) begin
            n_bad++;
            $display("FAIL consume drained: got hit=%b count=%0d expected 0/3", hit, count);
        end
        x_pos = 8'd77;
        consume = 1'b1;
        @(posedge clk); #1 consume = 1'b0;
        x_pos = 8'd0;
        #1;
        n_cmp++;
        if (hit !== 1'b1 || hit_idx !== 6'd9) begin
            n_bad++;
            $display("FAIL consume no-hit ignored: got hit=%b idx=%0d expected 1/9", hit, hit_idx);
        end
    endtask

    task automatic test_back_to_back();
        int dc, bc;
        set_oam(8'd0, 8'd1);
        for (int k = 0; k < 5; k++) oam_y[k] = 8'd16;
        for (int k = 5; k < 10; k++) oam_y[k] = 8'd116;
        ly = 8'd0;
        obj_size = 1'b0;
        push_expected();
        do_scan(40, 8'd100, dc, bc);
        n_cmp++;
        if (dc !== 121 || bc !== 120) begin
            n_bad++;
            $display("FAIL restart done/busy cycles: got %0d/%0d expected 121/120", dc, bc);
        end
        drain_scoreboard("restart");
        @(negedge clk) x_pos = 8'd1;
        #1;
        n_cmp++;
        if (hit !== 1'b0) begin
            n_bad++;
            $display("FAIL restart stale first-scan slot: got %b expected 0", hit);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundaries();
        test_overflow();
        test_consume();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
